// File: rtl/vga_text_pkg.sv
// Shared constants for the text-mode pixel engine: attribute word layout,
// colour width and helpers for derived dimensions.
package vga_text_pkg;

  localparam int COLOR_W  = 9;

  localparam int FG_LSB   = 0;
  localparam int FG_MSB   = 8;
  localparam int BG_LSB   = 9;
  localparam int BG_MSB   = 17;
  localparam int BRD_BIT  = 18;
  localparam int BLK_BIT  = 19;
  localparam int FONT_LSB = 24;
  localparam int FONT_MSB = 31;

  // Cell size is the glyph plus its border padding (1 column, 2 rows).
  function automatic int cell_dim(input int glyph, input int pad);
    return glyph + pad;
  endfunction

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_text_engine_if.sv
// Signal bundle between the text engine and its environment (raster control,
// attribute writes, cursor, font ROM and pixel output).
interface vga_text_engine_if #(
  parameter int COLS    = 32,
  parameter int ROWS    = 12,
  parameter int GLYPH_W = 24,
  parameter int GLYPH_H = 48
);
  localparam int RW = vga_text_pkg::idx_w(ROWS);
  localparam int CW = vga_text_pkg::idx_w(COLS);
  localparam int AW = vga_text_pkg::idx_w(GLYPH_W * GLYPH_H);

  // pix_en is a one-way accept strobe with no backpressure: each cycle it is
  // high one pixel is consumed. pix_valid alone qualifies pix_color, and
  // rom_rdata must answer the rom_addr/rom_font of the previous cycle.
  logic          pix_en;
  logic          frame_start;
  logic          wr_en;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic [31:0]   wr_data;
  logic          cursor_en;
  logic [RW-1:0] cursor_row;
  logic [CW-1:0] cursor_col;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_font;
  logic          rom_rdata;
  logic [vga_text_pkg::COLOR_W-1:0] pix_color;
  logic          pix_valid;
  logic          frame_done;

  modport master (
    output pix_en, frame_start, wr_en, wr_row, wr_col, wr_data,
           cursor_en, cursor_row, cursor_col, rom_rdata,
    input  rom_addr, rom_font, pix_color, pix_valid, frame_done
  );

  modport slave (
    input  pix_en, frame_start, wr_en, wr_row, wr_col, wr_data,
           cursor_en, cursor_row, cursor_col, rom_rdata,
    output rom_addr, rom_font, pix_color, pix_valid, frame_done
  );
endinterface

// File: rtl/vga_attr_ram.sv
// Per-cell attribute store: one write port, one synchronous read port,
// a same-address read returns the word held before the write.
module vga_attr_ram #(
  parameter int DEPTH = 384,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/vga_text_engine.sv
// Character-cell pixel engine: raster walk, attribute lookup, font ROM
// addressing and colour merge with border, blink and cursor.
module vga_text_engine
  import vga_text_pkg::*;
#(
  parameter int COLS         = 32,
  parameter int ROWS         = 12,
  parameter int GLYPH_W      = 24,
  parameter int GLYPH_H      = 48,
  parameter int BLINK_FRAMES = 30,
  parameter logic [COLOR_W-1:0] BORDER_COLOR = 9'h1FF
) (
  input logic clk,
  input logic rst,
  vga_text_engine_if.slave bus
);
  localparam int CELL_W = cell_dim(GLYPH_W, 1);
  localparam int CELL_H = cell_dim(GLYPH_H, 2);
  localparam int RW     = idx_w(ROWS);
  localparam int CW     = idx_w(COLS);
  localparam int AW     = idx_w(GLYPH_W * GLYPH_H);
  localparam int PXW    = idx_w(CELL_W);
  localparam int PYW    = idx_w(CELL_H);
  localparam int DEPTH  = COLS * ROWS;
  localparam int RAW    = idx_w(DEPTH);
  localparam int FCW    = idx_w(BLINK_FRAMES);

  localparam logic [PXW-1:0] PX_LAST  = PXW'(CELL_W - 1);
  localparam logic [CW-1:0]  COL_LAST = CW'(COLS - 1);
  localparam logic [PYW-1:0] PY_LAST  = PYW'(CELL_H - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(ROWS - 1);
  localparam logic [FCW-1:0] FC_LAST  = FCW'(BLINK_FRAMES - 1);

  logic [PXW-1:0] px_q, px_d, rpx, npx;
  logic [CW-1:0]  col_q, col_d, rcol, ncol;
  logic [PYW-1:0] py_q, py_d, rpy, npy;
  logic [RW-1:0]  row_q, row_d, rrow, nrow;
  logic           at_last, frame_done, border, cursor_hit, wr_ok;
  logic [31:0]    addr_full;
  logic [AW-1:0]  rom_addr_q, rom_addr_d;
  logic [RAW-1:0] rd_addr, wr_addr;
  logic [31:0]    attr_rdata;
  logic           s1_valid_q, s1_border_q, s1_cursor_q, s1_phase_q;
  logic           s2_valid_q, s2_border_q, s2_cursor_q, s2_phase_q;
  logic [BLK_BIT:0] s2_attr_q;
  logic [COLOR_W-1:0] fg, bg, color_d, pix_color_q;
  logic           pix_valid_q;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           blink_phase_q, blink_phase_d;
  logic           unused_rsvd;

  // Raster: frame_start renders the current pixel as the origin, so the
  // advance is always computed from the rendered position.
  always_comb begin
    rpx  = bus.frame_start ? '0 : px_q;
    rcol = bus.frame_start ? '0 : col_q;
    rpy  = bus.frame_start ? '0 : py_q;
    rrow = bus.frame_start ? '0 : row_q;
    npx  = rpx + PXW'(1);
    ncol = rcol;
    npy  = rpy;
    nrow = rrow;
    if (rpx == PX_LAST) begin
      npx  = '0;
      ncol = rcol + CW'(1);
      if (rcol == COL_LAST) begin
        ncol = '0;
        npy  = rpy + PYW'(1);
        if (rpy == PY_LAST) begin
          npy  = '0;
          nrow = (rrow == ROW_LAST) ? '0 : rrow + RW'(1);
        end
      end
    end
    px_d  = px_q;
    col_d = col_q;
    py_d  = py_q;
    row_d = row_q;
    if (bus.pix_en) begin
      px_d  = npx;
      col_d = ncol;
      py_d  = npy;
      row_d = nrow;
    end else if (bus.frame_start) begin
      px_d  = '0;
      col_d = '0;
      py_d  = '0;
      row_d = '0;
    end
    at_last    = (px_q == PX_LAST) && (col_q == COL_LAST) &&
                 (py_q == PY_LAST) && (row_q == ROW_LAST);
    frame_done = !rst && bus.pix_en && !bus.frame_start && at_last;
  end

  always_comb begin
    border     = (rpx == '0) || (rpy == '0) || (rpy == PY_LAST);
    addr_full  = (32'(rpy) - 32'd1) * 32'(GLYPH_W) + (32'(rpx) - 32'd1);
    rom_addr_d = border ? '0 : AW'(addr_full);
    cursor_hit = bus.cursor_en && (bus.cursor_row == rrow) && (bus.cursor_col == rcol);
    rd_addr    = RAW'(32'(rrow) * 32'(COLS) + 32'(rcol));
    wr_addr    = RAW'(32'(bus.wr_row) * 32'(COLS) + 32'(bus.wr_col));
    wr_ok      = bus.wr_en && (int'(bus.wr_row) < ROWS) && (int'(bus.wr_col) < COLS);
  end

  vga_attr_ram #(.DEPTH(DEPTH), .AW(RAW)) u_attr_ram (
    .clk     (clk),
    .we_i    (wr_ok),
    .waddr_i (wr_addr),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_addr),
    .rdata_o (attr_rdata)
  );

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_done) begin
      if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FCW'(1);
      end
    end
  end

  // Earlier rules win: border, cursor inversion, blink-off, plain glyph.
  always_comb begin
    fg = s2_attr_q[FG_MSB:FG_LSB];
    bg = s2_attr_q[BG_MSB:BG_LSB];
    if (s2_border_q)                    color_d = s2_attr_q[BRD_BIT] ? BORDER_COLOR : bg;
    else if (s2_cursor_q && s2_phase_q) color_d = bus.rom_rdata ? bg : fg;
    else if (s2_attr_q[BLK_BIT] && !s2_phase_q) color_d = bg;
    else                                color_d = bus.rom_rdata ? fg : bg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      px_q <= '0; col_q <= '0; py_q <= '0; row_q <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      px_q <= px_d; col_q <= col_d; py_q <= py_d; row_q <= row_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Blink phase travels with the pixel so a frame's tail uses that frame's phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0; s1_border_q <= 1'b0; s1_cursor_q <= 1'b0; s1_phase_q <= 1'b0;
      s2_valid_q <= 1'b0; s2_border_q <= 1'b0; s2_cursor_q <= 1'b0; s2_phase_q <= 1'b0;
      s2_attr_q   <= '0;
      rom_addr_q  <= '0;
      pix_valid_q <= 1'b0;
      pix_color_q <= '0;
    end else begin
      s1_valid_q <= bus.pix_en;
      if (bus.pix_en) begin
        s1_border_q <= border;
        s1_cursor_q <= cursor_hit;
        s1_phase_q  <= blink_phase_q;
        rom_addr_q  <= rom_addr_d;
      end
      s2_valid_q  <= s1_valid_q;
      s2_border_q <= s1_border_q;
      s2_cursor_q <= s1_cursor_q;
      s2_phase_q  <= s1_phase_q;
      s2_attr_q   <= attr_rdata[BLK_BIT:0];
      pix_valid_q <= s2_valid_q;
      if (s2_valid_q) pix_color_q <= color_d;
    end
  end

  assign unused_rsvd    = ^attr_rdata[FONT_LSB-1:BLK_BIT+1];
  assign bus.rom_addr   = rom_addr_q;
  assign bus.rom_font   = s1_valid_q ? attr_rdata[FONT_MSB:FONT_LSB] : 8'h00;
  assign bus.pix_color  = pix_color_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_vga_text_engine.sv
// Directed-plus-random bench for vga_text_engine against a linear-index
// raster model with a scoreboard of expected pixel colours.
module tb_vga_text_engine;
  import vga_text_pkg::*;

  localparam int T_COLS = 6;
  localparam int T_ROWS = 4;
  localparam int T_GW   = 3;
  localparam int T_GH   = 2;
  localparam int T_BF   = 2;
  localparam logic [8:0] T_BORDER = 9'h155;
  localparam int CW_    = T_GW + 1;
  localparam int CH_    = T_GH + 2;
  localparam int FRAME  = CW_ * T_COLS * CH_ * T_ROWS;
  localparam int RWB    = idx_w(T_ROWS);
  localparam int CWB    = idx_w(T_COLS);
  localparam int AWB    = idx_w(T_GW * T_GH);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_text_engine_if #(.COLS(T_COLS), .ROWS(T_ROWS), .GLYPH_W(T_GW), .GLYPH_H(T_GH)) bus();

  vga_text_engine #(
    .COLS(T_COLS), .ROWS(T_ROWS), .GLYPH_W(T_GW), .GLYPH_H(T_GH),
    .BLINK_FRAMES(T_BF), .BORDER_COLOR(T_BORDER)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks, errors;
  int p, frames;
  logic [31:0] attr_m [T_ROWS][T_COLS];
  logic rom_force, rom_pend, cur_en;
  int cur_row, cur_col;
  logic exp_v_q[$];
  logic [8:0] exp_q[$];
  logic [8:0] exp_color;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (p=%0d frames=%0d)", tag, obs, exp, p, frames);
    end
  endtask

  function automatic logic glyph_bit(input logic [7:0] font, input int addr);
    int h;
    h = int'(font) * 7 + addr * 13 + 3;
    return h[2];
  endfunction

  function automatic logic [8:0] model_color(input logic [31:0] a, input logic brd_pix,
                                             input logic on_cursor, input logic phase,
                                             input logic bit_on);
    logic [8:0] fg, bg;
    fg = a[8:0];
    bg = a[17:9];
    if (brd_pix) return a[18] ? T_BORDER : bg;
    if (on_cursor && phase) return bit_on ? bg : fg;
    if (a[19] && !phase) return bg;
    return bit_on ? fg : bg;
  endfunction

  // One clock: drive inputs, check frame_done, advance model, check outputs.
  task automatic step(input logic pe, input logic fs, input logic r, input logic we,
                      input int wrow, input int wcol, input logic [31:0] wd);
    int rp, px, col, py, row;
    logic exp_fd, phase, brd_pix, cur_v, v;
    logic [8:0] c;
    logic [AWB-1:0] ea;
    logic [7:0] ef;
    logic [31:0] a;
    rst = r;
    bus.pix_en = pe;
    bus.frame_start = fs;
    bus.wr_en = we;
    bus.wr_row = RWB'(wrow);
    bus.wr_col = CWB'(wcol);
    bus.wr_data = wd;
    bus.cursor_en = cur_en;
    bus.cursor_row = RWB'(cur_row);
    bus.cursor_col = CWB'(cur_col);
    #1;
    rp = fs ? 0 : p;
    exp_fd = !r && pe && !fs && (p == FRAME - 1);
    chk("frame_done", 32'(bus.frame_done), 32'(exp_fd));
    px  = rp % CW_;
    col = (rp / CW_) % T_COLS;
    py  = (rp / (CW_ * T_COLS)) % CH_;
    row = rp / (CW_ * T_COLS * CH_);
    a = attr_m[row][col];
    phase = ((frames / T_BF) % 2) == 0;
    brd_pix = (px == 0) || (py == 0) || (py == CH_ - 1);
    ea = brd_pix ? '0 : AWB'((py - 1) * T_GW + px - 1);
    ef = a[31:24];
    cur_v = pe && !r;
    c = model_color(a, brd_pix, cur_en && (cur_row == row) && (cur_col == col), phase,
                    rom_force ? 1'b1 : glyph_bit(ef, int'(ea)));
    if (we && wrow < T_ROWS && wcol < T_COLS) attr_m[wrow][wcol] = wd;
    if (r) begin
      p = 0;
      frames = 0;
    end else if (pe) begin
      if (exp_fd) frames++;
      p = (rp + 1) % FRAME;
    end else if (fs) begin
      p = 0;
    end
    @(posedge clk);
    #1;
    if (r) begin
      exp_v_q.delete();
      exp_q.delete();
      exp_v_q.push_back(1'b0);
      exp_v_q.push_back(1'b0);
      exp_color = '0;
      chk("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
      chk("rst_pix_color", 32'(bus.pix_color), 32'd0);
      chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
      chk("rst_rom_font", 32'(bus.rom_font), 32'd0);
    end else begin
      exp_v_q.push_back(cur_v);
      if (cur_v) exp_q.push_back(c);
      v = exp_v_q.pop_front();
      if (v) exp_color = exp_q.pop_front();
      chk("pix_valid", 32'(bus.pix_valid), 32'(v));
      chk("pix_color", 32'(bus.pix_color), 32'(exp_color));
      if (cur_v) begin
        chk("rom_addr", 32'(bus.rom_addr), 32'(ea));
        chk("rom_font", 32'(bus.rom_font), 32'(ef));
      end
    end
    // Synchronous ROM: answer last cycle's address during this cycle.
    bus.rom_rdata = rom_pend;
    rom_pend = rom_force ? 1'b1 : glyph_bit(bus.rom_font, int'(bus.rom_addr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'd0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; p = 0; frames = 0;
    rom_force = 1'b1; rom_pend = 1'b0; cur_en = 1'b0; cur_row = 0; cur_col = 0;
    exp_color = '0;
    bus.rom_rdata = 1'b0;

    // Reset, including a cycle with pix_en high that must be discarded.
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 32'd0);

    for (int r = 0; r < T_ROWS; r++)
      for (int c = 0; c < T_COLS; c++)
        step(1'b0, 1'b0, 1'b0, 1'b1, r, c, $urandom());

    // Cell (0,0): font 41, FG 1C0, BG 007, ROM returns 1 everywhere.
    step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, {8'h41, 4'h0, 1'b0, 1'b0, 9'h007, 9'h1C0});
    run(2 * CW_ * T_COLS + 6);
    idle(4);

    // Random ROM, cursor at (3,5), bubbles and writes incl. out-of-range columns.
    rom_force = 1'b0;
    cur_en = 1'b1; cur_row = 3; cur_col = 5;
    step(1'b0, 1'b0, 1'b0, 1'b1, 3, 5, {8'h5A, 4'h0, 1'b0, 1'b0, 9'h00F, 9'h0F0});
    idle(2);
    for (int i = 0; i < 3 * FRAME; i++) begin
      int wr, wc;
      logic wv;
      wr = $urandom_range(0, T_ROWS - 1);
      wc = $urandom_range(0, 7);
      wv = ($urandom_range(0, 7) == 0) && !(wr == 3 && wc == 5);
      step($urandom_range(0, 3) != 0, 1'b0, 1'b0, wv, wr, wc, $urandom());
    end
    idle(4);

    // Blink over further frames with a solid glyph and a blinking cell.
    rom_force = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1, 2, {8'h33, 4'h0, 1'b1, 1'b0, 9'h022, 9'h1E0});
    idle(2);
    run(2 * FRAME);
    idle(4);

    // frame_start mid-row with pix_en, then with pix_en low.
    rom_force = 1'b0;
    run(40);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 32'd0);
    run(8);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 32'd0);
    run(5);
    // frame_start on the last pixel of a frame must not pulse frame_done.
    for (int i = 0; i < FRAME && p != FRAME - 1; i++) run(1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 32'd0);
    run(6);

    // Bubble pattern 1,0,1 with a write to the cell being read.
    begin
      int cr, cc;
      cr = p / (CW_ * T_COLS * CH_);
      cc = (p / CW_) % T_COLS;
      step(1'b1, 1'b0, 1'b0, 1'b1, cr, cc, $urandom());
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 32'd0);

    // Reset with pixels in flight.
    run(2);
    step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 32'd0);
    idle(4);
    run(12);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_text_engine.md
Name: vga_text_engine

Overview:
- Parametrised character-cell (text-mode) pixel engine for the VGA path.
- Holds a per-cell 32-bit attribute RAM written by the bus-side register block.
- Walks a raster of COLS x ROWS cells on each accepted pixel and generates font-ROM addresses.
- Merges the returned glyph bit with foreground/background colour, border, per-cell blink and a hardware cursor into a registered 9-bit pixel colour.

Parameters:
- COLS, 32, character cells per text row (1..64)
- ROWS, 12, character rows per frame (1..32)
- GLYPH_W, 24, glyph pixel width
- GLYPH_H, 48, glyph pixel height
- BLINK_FRAMES, 30, frames per blink half-period (>=1)
- BORDER_COLOR, 9'h1FF, colour of cell-border pixels when attribute bit BRD=1

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  one pixel accepted this cycle; raster advances
- frame_start  in  1  resynchronise raster to origin
- wr_en  in  1  attribute write strobe
- wr_row  in  clog2(ROWS)  attribute row address
- wr_col  in  clog2(COLS)  attribute column address
- wr_data  in  32  attribute word
- cursor_en  in  1  hardware cursor enable
- cursor_row  in  clog2(ROWS)  cursor row
- cursor_col  in  clog2(COLS)  cursor column
- rom_addr  out  clog2(GLYPH_W*GLYPH_H)  bit address inside glyph
- rom_font  out  8  glyph index
- rom_rdata  in  1  glyph bit, synchronous ROM, valid 1 cycle after rom_addr/rom_font
- pix_color  out  9  registered pixel colour
- pix_valid  out  1  pix_color carries a pixel
- frame_done  out  1  one-cycle pulse on the last pixel of a frame

Behaviour:
- Derived constants: CELL_W=GLYPH_W+1; CELL_H=GLYPH_H+2.
- Attribute word: FG [8:0]; BG [17:9]; BRD [18]; BLK [19]; [23:20] reserved, ignored; FONT [31:24].
- Raster counters: px (0..CELL_W-1), col, py (0..CELL_H-1), row; scan order is px innermost, then col, then py, then row.
- All counters change only when pix_en=1.
  - px wraps at CELL_W-1 and increments col.
  - col wraps at COLS-1 and increments py.
  - py wraps at CELL_H-1 and increments row.
  - row wraps at ROWS-1 to 0.
- Border pixel: px==0, py==0 or py==CELL_H-1. On a border pixel rom_addr=0.
- Otherwise rom_addr=(py-1)*GLYPH_W+(px-1), computed at full width with no truncation before the final result.
- Pipeline, with pix_en high in cycle t:
  - S0 (cycle t): attribute RAM read at {row,col}.
  - S1 (cycle t+1): registered attribute, px/py/border/cursor flags; rom_addr/rom_font driven from S1 registers.
  - S2 (cycle t+2): rom_rdata valid; colour computed.
  - Registered result: pix_color/pix_valid at t+3.
  - Throughput is one pixel per cycle; bubbles in pix_en propagate as pix_valid=0 bubbles.
- Colour select, in order (earlier rule wins):
  1. Border pixel: BORDER_COLOR if BRD=1, else BG.
  2. Cursor cell (cursor_en=1, row/col match) and blink_phase=1: FG and BG are swapped.
  3. BLK=1 and blink_phase=0: glyph suppressed and BG is output.
  4. Otherwise rom_rdata ? FG : BG.
- When pix_valid=0, pix_color holds its last value.
- Blink: frame counter increments on each frame_done. On reaching BLINK_FRAMES-1 it returns to 0 and blink_phase toggles.
- frame_done: asserted in the cycle pix_en accepts the pixel (px=CELL_W-1, col=COLS-1, py=CELL_H-1, row=ROWS-1), i.e. the pixel on which all four counters wrap. It is a raster event, not pipeline-delayed.
- frame_start: overrides the normal advance.
  - With pix_en=0: all counters load 0.
  - With pix_en=1: the current pixel is rendered as origin (0,0,0,0) and counters load px=1 (or the proper wrap if CELL_W=1).
  - frame_start does not pulse frame_done and does not touch blink state.
- Attribute RAM: COLS*ROWS x 32, one write port and one synchronous read port.
  - A simultaneous write and read of the same cell returns old data (read-before-write).
  - Writes with out-of-range row/col are dropped.
  - RAM contents are not reset.
- Reset (rst=1 at a clock edge):
  - px/col/py/row=0; pipeline valids=0; pix_valid=0; pix_color=0; frame_done=0.
  - Frame counter=0; blink_phase=1; rom_addr=0; rom_font=0.
  - Reset mid-frame discards in-flight pixels; no pix_valid is produced for them.

Decomposition:
- Package vga_text_pkg holds:
  - attribute bit-field localparams (FG_LSB/MSB, BG_LSB/MSB, BRD_BIT, BLK_BIT, FONT_LSB/MSB);
  - COLOR_W=9;
  - a function for the cell-dimension constants.
- One sub-module, vga_attr_ram: parametrised depth, 32-bit 1W1R synchronous-read, read-before-write.
- Raster counters, pipeline and colour merge stay in vga_text_engine.

Test Plan:
- Reset, then write cell (0,0)=FONT 8'h41, FG 9'h1C0, BG 9'h007; drive pix_en continuously with rom_rdata=1 → first pix_valid 3 cycles after first pix_en; border pixel (px=0) gives 9'h007; pixel px=1,py=1 gives rom_addr=0, rom_font=8'h41, color 9'h1C0.
- Default parameters, pix_en stuck high for 32*25*50*12=480000 cycles → frame_done pulses exactly once, on cycle 479999; raster returns to origin.
- BLINK_FRAMES=2, cell BLK=1, rom_rdata=1 → glyph shows FG for frames 0-1, BG for frames 2-3, FG again for frames 4-5.
- cursor_en=1, cursor at (3,5), cell FG 9'h0F0/BG 9'h00F, rom_rdata=1 → glyph pixels there output 9'h00F while blink_phase=1 and 9'h0F0 while blink_phase=0.
- frame_start pulsed mid-row with pix_en=1 → rom_addr for that pixel corresponds to origin; next accepted pixel has px=1; no frame_done pulse.
- pix_en toggled 1,0,1 and wr_en to the cell being read in the same cycle; rst asserted mid-frame → pix_valid shows the same bubble pattern delayed by 3; the read returns old attribute; after rst, pix_valid=0 and pix_color=0 until new pixels are accepted.
